rx_cmd_decoder: RTL and testbench

RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

---
 rtl/uart_sys_pkg.sv | 13 +
 rtl/rx_cmd_timer.sv | 18 +
 rtl/rx_cmd_decoder.sv | 96 +++++++++
 tb/tb_rx_cmd_decoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uart_sys_pkg.sv
// uart_sys_pkg: command codes and the one-hot state encoding shared by the UART command path.
package uart_sys_pkg;
  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;
  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    WR_ADDR = 6'b000010,
    WR_DATA = 6'b000100,
    RD_ADDR = 6'b001000,
    RD_WAIT = 6'b010000,
    TX_SEND = 6'b100000
  } state_t;
endpackage

// File: rtl/rx_cmd_timer.sv
// rx_cmd_timer: counts idle cycles while a frame is being collected; expire fires on the cycle the count reaches TIMEOUT_CYC.
module rx_cmd_timer #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic CLK,
  input  logic RST,
  input  logic active,
  input  logic rx_vld,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  assign expire = active && !rx_vld && cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt <= '0;
    else cnt <= (!active || rx_vld || expire) ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder: decodes UART write (0xAA addr data) and read (0xBB addr) frames into register-file strobes and read-back TX.
// Define RX_CMD_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYC cycles between bytes.
module rx_cmd_decoder
  import uart_sys_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic              PAR_ERR,
  input  logic              STP_ERR,
  output logic              WrEn,
  output logic              RdEn,
  output logic [ADDR_W-1:0] Address,
  output logic [7:0]        WrData,
  input  logic [7:0]        RdData,
  input  logic              RdData_VLD,
  output logic [7:0]        TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              TX_BUSY,
  output logic              FRAME_ERR
);
  state_t state;
  logic   rx_err;
  logic   tmo;
  assign rx_err = RX_D_VLD && (PAR_ERR || STP_ERR);
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end
`ifdef RX_CMD_TIMEOUT_EN
  rx_cmd_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .active (state inside {WR_ADDR, WR_DATA, RD_ADDR}),
    .rx_vld (RX_D_VLD),
    .expire (tmo)
  );
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      FRAME_ERR <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
    end else begin
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      FRAME_ERR <= 1'b0;
      // a corrupted byte aborts any frame, but a pending TX reply is never dropped
      if ((rx_err && state != TX_SEND) || tmo) begin
        state     <= IDLE;
        FRAME_ERR <= 1'b1;
      end else begin
        case (state)
          IDLE: if (RX_D_VLD) begin
            state     <= RX_P_DATA == CMD_WR ? WR_ADDR : RX_P_DATA == CMD_RD ? RD_ADDR : IDLE;
            FRAME_ERR <= RX_P_DATA != CMD_WR && RX_P_DATA != CMD_RD;
          end
          WR_ADDR: if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR_W-1:0];
            state   <= WR_DATA;
          end
          WR_DATA: if (RX_D_VLD) begin
            WrData <= RX_P_DATA;
            WrEn   <= 1'b1;
            state  <= IDLE;
          end
          RD_ADDR: if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR_W-1:0];
            RdEn    <= 1'b1;
            state   <= RD_WAIT;
          end
          RD_WAIT: if (RdData_VLD) begin
            TX_P_DATA <= RdData;
            TX_D_VLD  <= 1'b1;
            state     <= TX_SEND;
          end
          TX_SEND: if (!TX_BUSY) begin
            TX_D_VLD <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_cmd_decoder.sv
// tb_rx_cmd_decoder: directed scenarios plus random traffic checked against a frame-level reference model.
module tb_rx_cmd_decoder;
  localparam int AW  = 4;
  localparam int TMO = 20;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_vld = 1'b0, par = 1'b0, stp = 1'b0;
  logic          wr_en, rd_en, frame_err, tx_vld;
  logic [AW-1:0] addr;
  logic [7:0]    wr_data, tx_data;
  logic [7:0]    rd_data = '0;
  logic          rd_vld = 1'b0, tx_busy = 1'b0;
  int n_tests = 0, n_fail = 0;
  logic [7:0]    frm[$];
  bit            rd_wait, tx_pend;
  int            idle;
  logic          e_wr, e_rd, e_fe, e_txv;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_wd, e_txd;

  rx_cmd_decoder #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .CLK(clk), .RST(rst), .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
    .PAR_ERR(par), .STP_ERR(stp), .WrEn(wr_en), .RdEn(rd_en),
    .Address(addr), .WrData(wr_data), .RdData(rd_data), .RdData_VLD(rd_vld),
    .TX_P_DATA(tx_data), .TX_D_VLD(tx_vld), .TX_BUSY(tx_busy), .FRAME_ERR(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    frm.delete();
    rd_wait = 0; tx_pend = 0; idle = 0;
    e_wr = 0; e_rd = 0; e_fe = 0; e_txv = 0;
    e_addr = '0; e_wd = '0; e_txd = '0;
  endtask

  // frame-level model: collect bytes, act when a frame is complete or invalid
  task automatic mstep();
    e_wr = 0; e_rd = 0; e_fe = 0;
    if (tx_pend) begin
      if (!tx_busy) begin tx_pend = 0; e_txv = 0; end
    end else if (rd_wait) begin
      if (rx_vld && (par || stp)) begin rd_wait = 0; e_fe = 1; end
      else if (rd_vld) begin rd_wait = 0; tx_pend = 1; e_txv = 1; e_txd = rd_data; end
    end else if (rx_vld) begin
      idle = 0;
      if (par || stp) begin frm.delete(); e_fe = 1; end
      else begin
        frm.push_back(rx_data);
        if (frm[0] != 8'hAA && frm[0] != 8'hBB) begin frm.delete(); e_fe = 1; end
        else if (frm.size() == 2) e_addr = frm[1][AW-1:0];
        if (frm.size() == 3 && frm[0] == 8'hAA) begin e_wd = frm[2]; e_wr = 1; frm.delete(); end
        if (frm.size() == 2 && frm[0] == 8'hBB) begin e_rd = 1; rd_wait = 1; frm.delete(); end
      end
    end
`ifdef RX_CMD_TIMEOUT_EN
    else if (frm.size() > 0) begin
      idle++;
      if (idle == TMO) begin frm.delete(); e_fe = 1; idle = 0; end
    end
`endif
  endtask

  task automatic check_all();
    chk("WrEn", 32'(wr_en), 32'(e_wr));
    chk("RdEn", 32'(rd_en), 32'(e_rd));
    chk("FRAME_ERR", 32'(frame_err), 32'(e_fe));
    chk("Address", 32'(addr), 32'(e_addr));
    chk("WrData", 32'(wr_data), 32'(e_wd));
    chk("TX_D_VLD", 32'(tx_vld), 32'(e_txv));
    chk("TX_P_DATA", 32'(tx_data), 32'(e_txd));
    chk("WrEn_RdEn_excl", 32'(wr_en & rd_en), 32'(0));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) mreset(); else mstep();
    #1 check_all();
  endtask

  task automatic send(input logic [7:0] b, input logic pe = 1'b0);
    rx_data = b; rx_vld = 1'b1; par = pe;
    cyc();
    rx_vld = 1'b0; par = 1'b0;
  endtask

  initial begin
    mreset();
    #12 check_all();
    rst = 1'b1;
    cyc();
    // write frame
    send(8'hAA); send(8'h05); send(8'h3C);
    chk("wr_pulse", 32'(wr_en), 32'(1));
    chk("wr_addr", 32'(addr), 32'h5);
    chk("wr_data", 32'(wr_data), 32'h3C);
    cyc();
    chk("wr_one_cycle", 32'(wr_en), 32'(0));
    // read frame with busy transmitter
    send(8'hBB); send(8'h02);
    chk("rd_pulse", 32'(rd_en), 32'(1));
    chk("rd_addr", 32'(addr), 32'h2);
    cyc();
    rd_data = 8'h81; rd_vld = 1'b1; tx_busy = 1'b1;
    cyc();
    rd_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("tx_hold_vld", 32'(tx_vld), 32'(1));
      chk("tx_hold_data", 32'(tx_data), 32'h81);
      if (i < 4) cyc();
    end
    tx_busy = 1'b0;
    cyc();
    chk("tx_drop", 32'(tx_vld), 32'(0));
    // bad command byte
    send(8'h55);
    chk("bad_cmd_fe", 32'(frame_err), 32'(1));
    // parity error on data byte, then a clean frame
    send(8'hAA); send(8'h03); send(8'h77, 1'b1);
    chk("par_fe", 32'(frame_err), 32'(1));
    chk("par_no_wr", 32'(wr_en), 32'(0));
    send(8'hAA); send(8'h07); send(8'h99);
    chk("recover_wr", 32'(wr_en), 32'(1));
    chk("recover_data", 32'(wr_data), 32'h99);
`ifdef RX_CMD_TIMEOUT_EN
    send(8'hAA);
    for (int i = 1; i <= TMO + 3; i++) begin
      cyc();
      if (i == TMO) chk("timeout_fe", 32'(frame_err), 32'(1));
    end
    send(8'hAA); send(8'h01); send(8'h42);
    chk("after_timeout_wr", 32'(wr_en), 32'(1));
`endif
    // asynchronous reset in WR_DATA
    send(8'hAA); send(8'h0C);
    #2 rst = 1'b0;
    #1;
    mreset();
    check_all();
    chk("rst_addr", 32'(addr), 32'(0));
    cyc(); cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("no_wr_after_rst", 32'(wr_en), 32'(0));
      chk("no_fe_after_rst", 32'(frame_err), 32'(0));
    end
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 9);
      rx_vld  = $urandom_range(0, 9) < 3;
      rx_data = r < 3 ? 8'hAA : r < 6 ? 8'hBB : 8'($urandom);
      par     = $urandom_range(0, 39) == 0;
      stp     = $urandom_range(0, 39) == 0;
      rd_vld  = $urandom_range(0, 4) == 0;
      rd_data = 8'($urandom);
      tx_busy = $urandom_range(0, 1) == 1;
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
